// File: rtl/y86_fetch_align_split.sv
// Y86-64 fetch field extractor: splits byte 0, aligns regids/valC,
// computes valP, and registers everything for decode and PC select.
module y86_fetch_align_split (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [63:0] pc,
  input  logic [79:0] instr_bytes,
  output logic        out_valid,
  output logic [3:0]  icode,
  output logic [3:0]  ifun,
  output logic [3:0]  rA,
  output logic [3:0]  rB,
  output logic [63:0] valC,
  output logic [63:0] valP,
  output logic        need_regids,
  output logic        need_valC,
  output logic        instr_valid
);

  logic [3:0]  ic_n;
  logic [3:0]  fn_n;
  logic        legal;
  logic        nr_raw;
  logic        nc_raw;
  logic        nr_n;
  logic        nc_n;
  logic [3:0]  ra_n;
  logic [3:0]  rb_n;
  logic [63:0] valc_n;
  logic [63:0] len_n;

  assign ic_n = instr_bytes[7:4];
  assign fn_n = instr_bytes[3:0];

  always_comb begin
    legal  = 1'b0;
    nr_raw = 1'b0;
    nc_raw = 1'b0;
    case (ic_n)
      4'h0, 4'h1, 4'h9: legal = (fn_n == 4'h0);
      4'h2: begin
        legal  = (fn_n <= 4'h6);
        nr_raw = 1'b1;
      end
      4'h3, 4'h4, 4'h5: begin
        legal  = (fn_n == 4'h0);
        nr_raw = 1'b1;
        nc_raw = 1'b1;
      end
      4'h6: begin
        legal  = (fn_n <= 4'h3);
        nr_raw = 1'b1;
      end
      4'h7: begin
        legal  = (fn_n <= 4'h6);
        nc_raw = 1'b1;
      end
      4'h8: begin
        legal  = (fn_n == 4'h0);
        nc_raw = 1'b1;
      end
      4'hA, 4'hB: begin
        legal  = (fn_n == 4'h0);
        nr_raw = 1'b1;
      end
      default: legal = 1'b0;
    endcase
  end

  // Illegal encodings fetch as a single byte with no fields.
  assign nr_n = legal & nr_raw;
  assign nc_n = legal & nc_raw;

  assign ra_n = nr_n ? instr_bytes[15:12] : 4'hF;
  assign rb_n = nr_n ? instr_bytes[11:8]  : 4'hF;

  always_comb begin
    valc_n = 64'd0;
    if (nc_n)
      valc_n = nr_n ? instr_bytes[79:16] : instr_bytes[71:8];
  end

  assign len_n = {60'd0, nc_n, 2'b00, nr_n} + 64'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid   <= 1'b0;
      icode       <= 4'h0;
      ifun        <= 4'h0;
      rA          <= 4'hF;
      rB          <= 4'hF;
      valC        <= 64'd0;
      valP        <= 64'd0;
      need_regids <= 1'b0;
      need_valC   <= 1'b0;
      instr_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        icode       <= ic_n;
        ifun        <= fn_n;
        rA          <= ra_n;
        rB          <= rb_n;
        valC        <= valc_n;
        valP        <= pc + len_n;
        need_regids <= nr_n;
        need_valC   <= nc_n;
        instr_valid <= legal;
      end
    end
  end

endmodule

// File: tb/tb_y86_fetch_align_split.sv
// Scoreboard bench for y86_fetch_align_split: directed vectors with
// hand-computed expectations checked by an independent monitor.
module tb_y86_fetch_align_split;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [63:0] pc;
  logic [79:0] instr_bytes;
  logic        out_valid;
  logic [3:0]  icode, ifun, rA, rB;
  logic [63:0] valC, valP;
  logic        need_regids, need_valC, instr_valid;

  typedef struct {
    string       name;
    logic        ov;
    logic [3:0]  ic;
    logic [3:0]  fn;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [63:0] vc;
    logic [63:0] vp;
    logic        nr;
    logic        nc;
    logic        iv;
  } exp_t;

  exp_t q[$];
  exp_t last;
  int   tests = 0;
  int   fails = 0;

  y86_fetch_align_split dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .pc(pc),
    .instr_bytes(instr_bytes), .out_valid(out_valid), .icode(icode),
    .ifun(ifun), .rA(rA), .rB(rB), .valC(valC), .valP(valP),
    .need_regids(need_regids), .need_valC(need_valC),
    .instr_valid(instr_valid)
  );

  always #5 clk = ~clk;

  // Monitor: checks the registered outputs once per cycle
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      bit bad;
      e = q.pop_front();
      bad = 1'b0;
      tests++;
      if (out_valid !== e.ov) begin
        bad = 1; $display("FAIL %s out_valid got %0b want %0b", e.name, out_valid, e.ov);
      end
      if (icode !== e.ic || ifun !== e.fn) begin
        bad = 1; $display("FAIL %s icode/ifun got %h/%h want %h/%h", e.name, icode, ifun, e.ic, e.fn);
      end
      if (rA !== e.ra || rB !== e.rb) begin
        bad = 1; $display("FAIL %s rA/rB got %h/%h want %h/%h", e.name, rA, rB, e.ra, e.rb);
      end
      if (valC !== e.vc) begin
        bad = 1; $display("FAIL %s valC got %h want %h", e.name, valC, e.vc);
      end
      if (valP !== e.vp) begin
        bad = 1; $display("FAIL %s valP got %h want %h", e.name, valP, e.vp);
      end
      if (need_regids !== e.nr || need_valC !== e.nc || instr_valid !== e.iv) begin
        bad = 1;
        $display("FAIL %s nr/nc/iv got %0b%0b%0b want %0b%0b%0b", e.name,
                 need_regids, need_valC, instr_valid, e.nr, e.nc, e.iv);
      end
      if (bad) fails++;
    end
  end

  task automatic step(input string nm, input logic rst, input logic v,
                      input logic [63:0] p, input logic [79:0] b,
                      input logic [3:0] ic, input logic [3:0] fn,
                      input logic [3:0] ra, input logic [3:0] rb,
                      input logic [63:0] vc, input logic [63:0] vp,
                      input logic nr, input logic nc, input logic iv);
    exp_t e;
    reset = rst; in_valid = v; pc = p; instr_bytes = b;
    e.name = nm; e.ov = v & ~rst; e.ic = ic; e.fn = fn; e.ra = ra; e.rb = rb;
    e.vc = vc; e.vp = vp; e.nr = nr; e.nc = nc; e.iv = iv;
    @(posedge clk);
    #1;
    q.push_back(e);
    last = e;
  endtask

  task automatic stall(input string nm);
    exp_t e;
    e = last;
    e.name = nm;
    e.ov = 1'b0;
    reset = 1'b0; in_valid = 1'b0;
    pc = 64'hDEAD_BEEF_0000_1234; instr_bytes = 80'h1234_5678_9ABC_DEF0_3060;
    @(posedge clk);
    #1;
    q.push_back(e);
    last = e;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; pc = '0; instr_bytes = '0;
    repeat (2) @(posedge clk);
    #1;
    step("reset", 1, 1, 64'h100, 80'h0123456789ABCDEFF430,
         4'h0, 4'h0, 4'hF, 4'hF, 64'd0, 64'd0, 0, 0, 0);
    step("irmovq", 0, 1, 64'h100, 80'h0123456789ABCDEFF430,
         4'h3, 4'h0, 4'hF, 4'h4, 64'h0123456789ABCDEF, 64'h10A, 1, 1, 1);
    step("jxx", 0, 1, 64'h20, 80'h30FFFFFFFFFFFFF41573,
         4'h7, 4'h3, 4'hF, 4'hF, 64'hFFFFFFFFFFFFF415, 64'h29, 0, 1, 1);
    step("opq", 0, 1, 64'h40, 80'hAAAAAAAAAAAAAAAA2360,
         4'h6, 4'h0, 4'h2, 4'h3, 64'd0, 64'h42, 1, 0, 1);
    step("ret", 0, 1, 64'h42, 80'h55555555555555555590,
         4'h9, 4'h0, 4'hF, 4'hF, 64'd0, 64'h43, 0, 0, 1);
    step("ill_ff", 0, 1, 64'h50, 80'hFFFFFFFFFFFFFFFFFFFF,
         4'hF, 4'hF, 4'hF, 4'hF, 64'd0, 64'h51, 0, 0, 0);
    step("ill_2f", 0, 1, 64'h60, 80'h112233445566778899_2F,
         4'h2, 4'hF, 4'hF, 4'hF, 64'd0, 64'h61, 0, 0, 0);
    stall("stall");
    step("call_wrap", 0, 1, 64'hFFFFFFFFFFFFFFFC, 80'hEE112233445566778880,
         4'h8, 4'h0, 4'hF, 4'hF, 64'h1122334455667788, 64'h5, 0, 1, 1);
    step("mrmovq", 0, 1, 64'h200, 80'h08070605040302011A50,
         4'h5, 4'h0, 4'h1, 4'hA, 64'h0807060504030201, 64'h20A, 1, 1, 1);
    step("cmov6", 0, 1, 64'h300, 80'hFFFFFFFFFFFFFFFFAB26,
         4'h2, 4'h6, 4'hA, 4'hB, 64'd0, 64'h302, 1, 0, 1);
    step("ill_op4", 0, 1, 64'h310, 80'h0000000000000000AB64,
         4'h6, 4'h4, 4'hF, 4'hF, 64'd0, 64'h311, 0, 0, 0);
    step("ill_j7", 0, 1, 64'h320, 80'h00112233445566778877,
         4'h7, 4'h7, 4'hF, 4'hF, 64'd0, 64'h321, 0, 0, 0);
    step("ill_pop1", 0, 1, 64'h330, 80'h0000000000000000F1B1,
         4'hB, 4'h1, 4'hF, 4'hF, 64'd0, 64'h331, 0, 0, 0);
    step("pushq", 0, 1, 64'h340, 80'hFFFFFFFFFFFFFFFF5FA0,
         4'hA, 4'h0, 4'h5, 4'hF, 64'd0, 64'h342, 1, 0, 1);
    step("halt", 0, 1, 64'h0, 80'hFFFFFFFFFFFFFFFFFF00,
         4'h0, 4'h0, 4'hF, 4'hF, 64'd0, 64'h1, 0, 0, 1);
    step("mid_reset", 1, 1, 64'h400, 80'h0123456789ABCDEFF430,
         4'h0, 4'h0, 4'hF, 4'hF, 64'd0, 64'd0, 0, 0, 0);
    stall("post_reset_idle");
    in_valid = 1'b0;
    for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      $display("FAIL drain %0d entries left want 0", q.size());
      fails++;
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
